// File: rtl/mem_ctrl_pkg.sv
// Shared constants and helpers for the byte-serial memory controller:
// FSM state encoding, request-size encoding, owner tags and the two
// memory-mapped IO addresses whose stores depend on IO buffer space.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } mc_state_t;

    typedef enum logic {
        OWN_IC  = 1'b0,
        OWN_LSB = 1'b1
    } mc_owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [31:0] IO_ADDR_0 = 32'h0003_0000;
    localparam logic [31:0] IO_ADDR_1 = 32'h0003_0004;

    // Index of the final byte of a transfer (N-1). The unused code 2'b11
    // is treated as a word so the FSM always terminates.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 2'd0;
            SIZE_HALF: return 2'd1;
            default:   return 2'd3;
        endcase
    endfunction

    // Little-endian byte lane selection.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating between instruction fetch (IC)
// and load/store (LSB) requests. One request is served at a time; the LSB
// wins ties. Reads gather bytes little-endian, stores emit bytes in order.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  rollback_in,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  ic_to_mc_ready,
    input  logic [ADDR_WIDTH-1:0] ic_to_mc_pc,
    output logic                  mc_to_ic_ready,
    output logic [31:0]           mc_to_ic_inst,
    input  logic                  lsb_to_mc_valid,
    input  logic                  lsb_to_mc_wr,
    input  logic [ADDR_WIDTH-1:0] lsb_to_mc_addr,
    input  logic [1:0]            lsb_to_mc_size,
    input  logic [31:0]           lsb_to_mc_data,
    output logic                  mc_to_lsb_ready,
    output logic [31:0]           mc_to_lsb_data
);

    mc_state_t             state_reg,    state_next;
    mc_owner_t             owner_reg,    owner_next;
    logic [1:0]            cnt_reg,      cnt_next;
    logic [1:0]            last_reg,     last_next;
    logic [ADDR_WIDTH-1:0] base_reg,     base_next;
    logic [31:0]           wdata_reg,    wdata_next;
    logic [31:0]           rbuf_reg,     rbuf_next;
    logic [ADDR_WIDTH-1:0] mem_a_reg,    mem_a_next;
    logic [7:0]            mem_dout_reg, mem_dout_next;
    logic                  mem_wr_reg,   mem_wr_next;
    logic                  ic_rdy_reg,   ic_rdy_next;
    logic [31:0]           ic_inst_reg,  ic_inst_next;
    logic                  lsb_rdy_reg,  lsb_rdy_next;
    logic [31:0]           lsb_data_reg, lsb_data_next;

    logic [ADDR_WIDTH-1:0] addr_step;
    logic [31:0]           captured;
    logic                  io_blocked;

    assign mem_a           = mem_a_reg;
    assign mem_dout        = mem_dout_reg;
    assign mem_wr          = mem_wr_reg;
    assign mc_to_ic_ready  = ic_rdy_reg;
    assign mc_to_ic_inst   = ic_inst_reg;
    assign mc_to_lsb_ready = lsb_rdy_reg;
    assign mc_to_lsb_data  = lsb_data_reg;

    // Stores to the IO ports stall while the IO buffer has no room.
    assign io_blocked = lsb_to_mc_wr && io_buffer_full &&
                        ((lsb_to_mc_addr == ADDR_WIDTH'(IO_ADDR_0)) ||
                         (lsb_to_mc_addr == ADDR_WIDTH'(IO_ADDR_1)));

    // Next-state and registered-output logic; ready pulses default low.
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        cnt_next      = cnt_reg;
        last_next     = last_reg;
        base_next     = base_reg;
        wdata_next    = wdata_reg;
        rbuf_next     = rbuf_reg;
        mem_a_next    = mem_a_reg;
        mem_dout_next = mem_dout_reg;
        mem_wr_next   = 1'b0;
        ic_rdy_next   = 1'b0;
        ic_inst_next  = ic_inst_reg;
        lsb_rdy_next  = 1'b0;
        lsb_data_next = lsb_data_reg;

        // Address of the next byte; truncation gives modulo-2^ADDR_WIDTH wrap.
        addr_step = base_reg + ADDR_WIDTH'(cnt_reg) + ADDR_WIDTH'(1);

        // Read buffer with the byte arriving this cycle merged into lane cnt.
        captured = rbuf_reg;
        case (cnt_reg)
            2'd0: captured[7:0]   = mem_din;
            2'd1: captured[15:8]  = mem_din;
            2'd2: captured[23:16] = mem_din;
            2'd3: captured[31:24] = mem_din;
        endcase

        unique case (state_reg)
            ST_IDLE: begin
                if (!rollback_in) begin
                    if (lsb_to_mc_valid && !io_blocked) begin
                        owner_next = OWN_LSB;
                        base_next  = lsb_to_mc_addr;
                        last_next  = last_index(lsb_to_mc_size);
                        cnt_next   = 2'd0;
                        mem_a_next = lsb_to_mc_addr;
                        rbuf_next  = 32'd0;
                        if (lsb_to_mc_wr) begin
                            state_next    = ST_WRITE;
                            wdata_next    = lsb_to_mc_data;
                            mem_wr_next   = 1'b1;
                            mem_dout_next = lsb_to_mc_data[7:0];
                        end else begin
                            state_next = ST_READ;
                        end
                    end else if (ic_to_mc_ready) begin
                        owner_next = OWN_IC;
                        base_next  = ic_to_mc_pc;
                        last_next  = last_index(SIZE_WORD);
                        cnt_next   = 2'd0;
                        mem_a_next = ic_to_mc_pc;
                        rbuf_next  = 32'd0;
                        state_next = ST_READ;
                    end
                end
            end

            ST_READ: begin
                if (rollback_in) begin
                    // Abandon the read silently; the requester will re-issue.
                    state_next = ST_IDLE;
                    mem_a_next = '0;
                    cnt_next   = 2'd0;
                end else begin
                    rbuf_next = captured;
                    if (cnt_reg == last_reg) begin
                        state_next = ST_DONE;
                        mem_a_next = '0;
                        if (owner_reg == OWN_IC) begin
                            ic_rdy_next  = 1'b1;
                            ic_inst_next = captured;
                        end else begin
                            lsb_rdy_next  = 1'b1;
                            lsb_data_next = captured;
                        end
                    end else begin
                        mem_a_next = addr_step;
                        cnt_next   = cnt_reg + 2'd1;
                    end
                end
            end

            ST_WRITE: begin
                // Stores run to completion regardless of rollback.
                if (cnt_reg == last_reg) begin
                    state_next   = ST_DONE;
                    mem_a_next   = '0;
                    lsb_rdy_next = 1'b1;
                end else begin
                    mem_wr_next   = 1'b1;
                    mem_a_next    = addr_step;
                    mem_dout_next = byte_sel(wdata_reg, cnt_reg + 2'd1);
                    cnt_next      = cnt_reg + 2'd1;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
                cnt_next   = 2'd0;
            end
        endcase
    end

    // State register: async reset clears everything, rdy_in low holds everything.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= OWN_IC;
            cnt_reg      <= 2'd0;
            last_reg     <= 2'd0;
            base_reg     <= '0;
            wdata_reg    <= 32'd0;
            rbuf_reg     <= 32'd0;
            mem_a_reg    <= '0;
            mem_dout_reg <= 8'd0;
            mem_wr_reg   <= 1'b0;
            ic_rdy_reg   <= 1'b0;
            ic_inst_reg  <= 32'd0;
            lsb_rdy_reg  <= 1'b0;
            lsb_data_reg <= 32'd0;
        end else if (rdy_in) begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            cnt_reg      <= cnt_next;
            last_reg     <= last_next;
            base_reg     <= base_next;
            wdata_reg    <= wdata_next;
            rbuf_reg     <= rbuf_next;
            mem_a_reg    <= mem_a_next;
            mem_dout_reg <= mem_dout_next;
            mem_wr_reg   <= mem_wr_next;
            ic_rdy_reg   <= ic_rdy_next;
            ic_inst_reg  <= ic_inst_next;
            lsb_rdy_reg  <= lsb_rdy_next;
            lsb_data_reg <= lsb_data_next;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte RAM model answers the DUT, and a
// separate reference memory predicts load/fetch results from the requests.
module tb_mem_ctrl;

    localparam int AW        = 32;
    localparam int RAM_BYTES = 1 << 18;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          rdy_in;
    logic          rollback_in;
    logic          io_buffer_full;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;
    logic          ic_to_mc_ready;
    logic [AW-1:0] ic_to_mc_pc;
    logic          mc_to_ic_ready;
    logic [31:0]   mc_to_ic_inst;
    logic          lsb_to_mc_valid;
    logic          lsb_to_mc_wr;
    logic [AW-1:0] lsb_to_mc_addr;
    logic [1:0]    lsb_to_mc_size;
    logic [31:0]   lsb_to_mc_data;
    logic          mc_to_lsb_ready;
    logic [31:0]   mc_to_lsb_data;

    int tests = 0;
    int fails = 0;
    logic [31:0] seed;

    // Physical RAM seen by the DUT (written only by DUT stores).
    logic [7:0] ram [0:RAM_BYTES-1];
    bit         written [0:RAM_BYTES-1];
    // Reference memory (written only from the requests the bench issues).
    logic [7:0] ref_mem [0:RAM_BYTES-1];
    bit         ref_written [0:RAM_BYTES-1];

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .rdy_in          (rdy_in),
        .rollback_in     (rollback_in),
        .io_buffer_full  (io_buffer_full),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout),
        .mem_a           (mem_a),
        .mem_wr          (mem_wr),
        .ic_to_mc_ready  (ic_to_mc_ready),
        .ic_to_mc_pc     (ic_to_mc_pc),
        .mc_to_ic_ready  (mc_to_ic_ready),
        .mc_to_ic_inst   (mc_to_ic_inst),
        .lsb_to_mc_valid (lsb_to_mc_valid),
        .lsb_to_mc_wr    (lsb_to_mc_wr),
        .lsb_to_mc_addr  (lsb_to_mc_addr),
        .lsb_to_mc_size  (lsb_to_mc_size),
        .lsb_to_mc_data  (lsb_to_mc_data),
        .mc_to_lsb_ready (mc_to_lsb_ready),
        .mc_to_lsb_data  (mc_to_lsb_data)
    );

    always #5 clk_in = ~clk_in;

    // Pseudo-random but reproducible power-up contents.
    function automatic logic [7:0] init_byte(input logic [17:0] a, input logic [31:0] s);
        logic [31:0] h;
        h = ({14'd0, a} ^ s) * 32'h9E37_79B1;
        return h[31:24];
    endfunction

    assign mem_din = written[mem_a[17:0]] ? ram[mem_a[17:0]] : init_byte(mem_a[17:0], seed);

    always @(posedge clk_in) begin
        if (mem_wr) begin
            ram[mem_a[17:0]]     <= mem_dout;
            written[mem_a[17:0]] <= 1'b1;
        end
    end

    function automatic logic [7:0] model_byte(input logic [31:0] addr);
        return ref_written[addr[17:0]] ? ref_mem[addr[17:0]] : init_byte(addr[17:0], seed);
    endfunction

    // N bytes from addr upward (address wraps at 2^32), zero-extended.
    function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = model_byte(addr + 32'(i));
        return v;
    endfunction

    task automatic model_write(input logic [31:0] addr, input int n, input logic [31:0] data);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            ref_mem[a[17:0]]     = data[8*i +: 8];
            ref_written[a[17:0]] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".mem_wr"},   32'(mem_wr), 32'd0);
        check({tag, ".mem_a"},    mem_a, 32'd0);
        check({tag, ".mem_dout"}, 32'(mem_dout), 32'd0);
        check({tag, ".ic_rdy"},   32'(mc_to_ic_ready), 32'd0);
        check({tag, ".ic_inst"},  mc_to_ic_inst, 32'd0);
        check({tag, ".lsb_rdy"},  32'(mc_to_lsb_ready), 32'd0);
        check({tag, ".lsb_data"}, mc_to_lsb_data, 32'd0);
    endtask

    // Issue one request from an idle controller and check completion,
    // latency (acceptance edge + N edges), data and single-cycle ready.
    task automatic run_txn(input string tag, input bit is_ic, input bit wr,
                           input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] data, output logic [31:0] got);
        int n;
        int edges;
        bit seen;
        logic [31:0] exp;
        n = is_ic ? 4 : (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        exp = model_read(addr, n);
        got = 32'd0;
        if (is_ic) begin
            ic_to_mc_ready = 1'b1;
            ic_to_mc_pc    = addr;
        end else begin
            lsb_to_mc_valid = 1'b1;
            lsb_to_mc_wr    = wr;
            lsb_to_mc_addr  = addr;
            lsb_to_mc_size  = size;
            lsb_to_mc_data  = data;
        end
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 30) begin
            tick();
            edges++;
            if (is_ic ? mc_to_ic_ready : mc_to_lsb_ready) begin
                seen = 1'b1;
                got  = is_ic ? mc_to_ic_inst : mc_to_lsb_data;
            end
        end
        ic_to_mc_ready  = 1'b0;
        lsb_to_mc_valid = 1'b0;
        check({tag, ".served"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, 32'(edges), 32'(n + 1));
        if (!wr) check({tag, ".data"}, got, exp);
        tick();
        check({tag, ".pulse"}, 32'(is_ic ? mc_to_ic_ready : mc_to_lsb_ready), 32'd0);
        if (wr) model_write(addr, n, data);
        $display("[TB] txn %s %s addr=%h n=%0d data=%h got=%h edges=%0d", tag,
                 is_ic ? "fetch" : (wr ? "store" : "load"), addr, n, data, got, edges);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got, w, r, addr;
        int lsb_edge, ic_edge, cnt_wr, cnt_rdy, kind;
        logic [31:0] lsb_got, ic_got;

        seed            = $urandom;
        rst_n_in        = 1'b1;
        rdy_in          = 1'b1;
        rollback_in     = 1'b0;
        io_buffer_full  = 1'b0;
        ic_to_mc_ready  = 1'b0;
        ic_to_mc_pc     = '0;
        lsb_to_mc_valid = 1'b0;
        lsb_to_mc_wr    = 1'b0;
        lsb_to_mc_addr  = '0;
        lsb_to_mc_size  = 2'b00;
        lsb_to_mc_data  = 32'd0;

        // Reset state
        #2 rst_n_in = 1'b0;
        #1 check_cleared("reset");
        tick();
        tick();
        rst_n_in = 1'b1;

        // Place known contents through the controller itself
        run_txn("setup_inst", 1'b0, 1'b1, 32'h1000, 2'b10, 32'h0000_0513, got);
        run_txn("setup_ff",   1'b0, 1'b1, 32'h2003, 2'b00, 32'h0000_00FF, got);

        // Instruction fetch, little-endian assembly
        run_txn("fetch_1000", 1'b1, 1'b0, 32'h1000, 2'b10, 32'd0, got);
        check("fetch_1000.const", got, 32'h0000_0513);

        // Simultaneous IC and LSB requests: LSB first, then IC
        ic_to_mc_ready  = 1'b1;
        ic_to_mc_pc     = 32'h1000;
        lsb_to_mc_valid = 1'b1;
        lsb_to_mc_wr    = 1'b0;
        lsb_to_mc_addr  = 32'h2003;
        lsb_to_mc_size  = 2'b00;
        lsb_edge = 0; ic_edge = 0; lsb_got = 32'd0; ic_got = 32'd0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (mc_to_lsb_ready && lsb_edge == 0) begin
                lsb_edge = e; lsb_got = mc_to_lsb_data; lsb_to_mc_valid = 1'b0;
            end
            if (mc_to_ic_ready && ic_edge == 0) begin
                ic_edge = e; ic_got = mc_to_ic_inst; ic_to_mc_ready = 1'b0;
            end
        end
        check("prio.lsb_edge", 32'(lsb_edge), 32'd2);
        check("prio.lsb_data", lsb_got, 32'h0000_00FF);
        check("prio.ic_edge",  32'(ic_edge), 32'd8);
        check("prio.ic_data",  ic_got, 32'h0000_0513);
        $display("[TB] txn prio lsb_edge=%0d ic_edge=%0d", lsb_edge, ic_edge);

        // Word store waveform
        w = 32'hDEAD_BEEF;
        check("st.idle_wr", 32'(mem_wr), 32'd0);
        lsb_to_mc_valid = 1'b1;
        lsb_to_mc_wr    = 1'b1;
        lsb_to_mc_addr  = 32'h100;
        lsb_to_mc_size  = 2'b10;
        lsb_to_mc_data  = w;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("st.wr%0d", k),   32'(mem_wr), 32'd1);
            check($sformatf("st.a%0d", k),    mem_a, 32'h100 + 32'(k));
            check($sformatf("st.dout%0d", k), 32'(mem_dout), 32'(w[8*k +: 8]));
        end
        tick();
        check("st.wr_end", 32'(mem_wr), 32'd0);
        check("st.ready",  32'(mc_to_lsb_ready), 32'd1);
        lsb_to_mc_valid = 1'b0;
        tick();
        check("st.pulse", 32'(mc_to_lsb_ready), 32'd0);
        model_write(32'h100, 4, w);
        $display("[TB] txn store_deadbeef addr=00000100");
        run_txn("ld_100", 1'b0, 1'b0, 32'h100, 2'b10, 32'd0, got);
        check("ld_100.const", got, 32'hDEAD_BEEF);

        // Rollback during the second READ cycle
        ic_to_mc_ready = 1'b1;
        ic_to_mc_pc    = 32'h1000;
        tick();
        check("rb.a0", mem_a, 32'h1000);
        tick();
        check("rb.a1", mem_a, 32'h1001);
        rollback_in    = 1'b1;
        ic_to_mc_ready = 1'b0;
        tick();
        check("rb.a_idle", mem_a, 32'd0);
        rollback_in = 1'b0;
        cnt_rdy = 0; cnt_wr = 0;
        for (int e = 0; e < 6; e++) begin
            tick();
            if (mc_to_ic_ready) cnt_rdy++;
            if (mem_wr) cnt_wr++;
        end
        check("rb.no_ready", 32'(cnt_rdy), 32'd0);
        check("rb.no_wr",    32'(cnt_wr), 32'd0);
        $display("[TB] txn rollback_read addr=00001000");

        // Rollback while idle blocks acceptance
        rollback_in    = 1'b1;
        ic_to_mc_ready = 1'b1;
        ic_to_mc_pc    = 32'h1000;
        for (int e = 0; e < 3; e++) begin
            tick();
            check($sformatf("rb_idle.a%0d", e), mem_a, 32'd0);
        end
        rollback_in = 1'b0;
        run_txn("rb_idle_fetch", 1'b1, 1'b0, 32'h1000, 2'b10, 32'd0, got);

        // rdy_in low freezes a read in progress
        r = model_read(32'h2000, 4);
        ic_to_mc_ready = 1'b1;
        ic_to_mc_pc    = 32'h2000;
        tick();
        tick();
        rdy_in = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            check($sformatf("stall.a%0d", e), mem_a, 32'h2001);
        end
        rdy_in = 1'b1;
        ic_edge = 0; ic_got = 32'd0;
        for (int e = 1; e <= 10 && ic_edge == 0; e++) begin
            tick();
            if (mc_to_ic_ready) begin ic_edge = e; ic_got = mc_to_ic_inst; end
        end
        ic_to_mc_ready = 1'b0;
        check("stall.edge", 32'(ic_edge), 32'd3);
        check("stall.data", ic_got, r);
        tick();
        $display("[TB] txn stall_fetch addr=00002000 edges=%0d", ic_edge);

        // IO store held off while the buffer is full; IC still served
        io_buffer_full  = 1'b1;
        lsb_to_mc_valid = 1'b1;
        lsb_to_mc_wr    = 1'b1;
        lsb_to_mc_addr  = 32'h3_0000;
        lsb_to_mc_size  = 2'b00;
        lsb_to_mc_data  = 32'h0000_00A5;
        ic_to_mc_ready  = 1'b1;
        ic_to_mc_pc     = 32'h1000;
        ic_edge = 0; cnt_wr = 0; cnt_rdy = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (mc_to_ic_ready && ic_edge == 0) begin ic_edge = e; ic_to_mc_ready = 1'b0; end
            if (mem_wr) cnt_wr++;
            if (mc_to_lsb_ready) cnt_rdy++;
        end
        check("io.ic_edge", 32'(ic_edge), 32'd5);
        check("io.no_wr",   32'(cnt_wr), 32'd0);
        check("io.no_rdy",  32'(cnt_rdy), 32'd0);
        io_buffer_full = 1'b0;
        tick();
        check("io.accept_wr", 32'(mem_wr), 32'd1);
        check("io.accept_a",  mem_a, 32'h3_0000);
        check("io.accept_d",  32'(mem_dout), 32'h0000_00A5);
        tick();
        check("io.ready", 32'(mc_to_lsb_ready), 32'd1);
        lsb_to_mc_valid = 1'b0;
        tick();
        model_write(32'h3_0000, 1, 32'h0000_00A5);
        $display("[TB] txn io_store addr=00030000 ic_edge=%0d", ic_edge);

        // Address wrap at the top of the space
        run_txn("wrap_st", 1'b0, 1'b1, 32'hFFFF_FFFF, 2'b01, 32'h0000_BEEF, got);
        run_txn("wrap_ld", 1'b0, 1'b0, 32'hFFFF_FFFE, 2'b10, 32'd0, got);
        run_txn("wrap_if", 1'b1, 1'b0, 32'hFFFF_FFFD, 2'b10, 32'd0, got);

        // Randomized traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            r    = $urandom;
            addr = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFFF - (r & 32'h7)) : (r & 32'h3_FFFF);
            run_txn($sformatf("rnd%0d", i), kind == 0, kind == 2, addr,
                    2'($urandom_range(0, 2)), $urandom, got);
        end

        // Reset in the middle of a store
        lsb_to_mc_valid = 1'b1;
        lsb_to_mc_wr    = 1'b1;
        lsb_to_mc_addr  = 32'h500;
        lsb_to_mc_size  = 2'b10;
        lsb_to_mc_data  = $urandom;
        tick();
        tick();
        check("rst_mid.wr_before", 32'(mem_wr), 32'd1);
        rst_n_in = 1'b0;
        #1 check_cleared("rst_mid");
        lsb_to_mc_valid = 1'b0;
        tick();
        tick();
        rst_n_in = 1'b1;
        cnt_rdy = 0; cnt_wr = 0;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (mc_to_lsb_ready || mc_to_ic_ready) cnt_rdy++;
            if (mem_wr) cnt_wr++;
        end
        check("rst_mid.no_ready", 32'(cnt_rdy), 32'd0);
        check("rst_mid.no_wr",    32'(cnt_wr), 32'd0);
        $display("[TB] txn reset_mid_store addr=00000500");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, shall set the width of all byte addresses.
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n_in  input  1  reset; asynchronous, active-low.
REQ-004 rdy_in  input  1  global enable; low freezes all state and outputs.
REQ-005 rollback_in  input  1  pipeline flush; aborts in-flight reads.
REQ-006 io_buffer_full  input  1  IO output buffer full.
REQ-007 mem_din  input  8  RAM read byte, valid one cycle after mem_a presented.
REQ-008 mem_dout  output  8  RAM write byte.
REQ-009 mem_a  output  ADDR_WIDTH  RAM byte address.
REQ-010 mem_wr  output  1  1 = write, 0 = read.
REQ-011 ic_to_mc_ready  input  1  instruction-fetch request valid, held until served.
REQ-012 ic_to_mc_pc  input  ADDR_WIDTH  fetch address (4-byte read).
REQ-013 mc_to_ic_ready  output  1  fetch complete pulse.
REQ-014 mc_to_ic_inst  output  32  fetched instruction, little-endian.
REQ-015 lsb_to_mc_valid  input  1  load/store request valid, held until served.
REQ-016 lsb_to_mc_wr  input  1  1 = store, 0 = load.
REQ-017 lsb_to_mc_addr  input  ADDR_WIDTH  load/store address.
REQ-018 lsb_to_mc_size  input  2  00 byte, 01 half, 10 word (N = 1/2/4 bytes).
REQ-019 lsb_to_mc_data  input  32  store data, low N bytes used.
REQ-020 mc_to_lsb_ready  output  1  load/store complete pulse.
REQ-021 mc_to_lsb_data  output  32  load data, zero-extended from N bytes.

Function
REQ-022 FSM states IDLE, READ, WRITE, DONE; exactly one request served at a time.
REQ-023 In IDLE, a valid LSB request shall win over a valid IC request.
REQ-024 Acceptance edge: latch base address, N, owner (IC/LSB), byte counter cnt<=0; mem_a<=base.
REQ-025 READ: each edge captures mem_din into byte cnt, drives mem_a<=base+cnt+1, cnt increments; edge capturing byte N-1 enters DONE, mem_a<=0.
REQ-026 WRITE: acceptance edge drives mem_wr<=1, mem_dout<=byte 0; each following edge drives next byte at base+cnt+1; after byte N-1 has been driven for one cycle, mem_wr<=0 and enter DONE.
REQ-027 Word read latency: 4 edges from acceptance to DONE entry; byte/half 1/2 edges; writes N edges.
REQ-028 DONE lasts exactly one cycle; owner's ready output high only in DONE with data stable; no request accepted in DONE; next state IDLE.
REQ-029 Address arithmetic base+cnt shall wrap modulo 2^ADDR_WIDTH.
REQ-030 Store to address 0x30000 or 0x30004 shall not be accepted while io_buffer_full=1; a pending IC request may be served meanwhile.
REQ-031 rollback_in=1 during READ (either owner) shall return to IDLE next edge, mem_a<=0, no ready pulse.
REQ-032 rollback_in=1 in IDLE shall block acceptance on that edge.
REQ-033 Stores shall never be aborted by rollback_in.
REQ-034 mem_wr shall be 0 in every state except WRITE.

Reset
REQ-035 rst_n_in low shall immediately force state IDLE, cnt 0, mem_a 0, mem_dout 0, mem_wr 0, both ready outputs 0, both data outputs 0.
REQ-036 Reset mid-transfer shall discard the transfer; no ready pulse after release.

Structure
REQ-037 State encodings, size encodings and IO address constants shall live in consts.v.
REQ-038 Single flat module; no sub-module.

Verification
REQ-039 IC fetch 0x1000, RAM bytes 13 05 00 00 -> mc_to_ic_inst=0x00000513, ready pulse one cycle, 4 edges after acceptance.
REQ-040 IC and LSB load (size 00, addr 0x2003, byte 0xFF) same cycle -> LSB served first, data 0x000000FF, then IC served.
REQ-041 LSB store word 0xDEADBEEF at 0x100 -> mem_a 0x100..0x103, mem_dout EF BE AD DE, mem_wr high exactly 4 cycles.
REQ-042 IC fetch, rollback_in on 2nd READ cycle -> IDLE next edge, no mc_to_ic_ready, mem_wr stays 0.
REQ-043 Store byte to 0x30000 with io_buffer_full=1 for 5 cycles -> no acceptance; accepted on first edge after it drops.
REQ-044 Assert rst_n_in low mid-store, release -> all outputs 0 immediately, no ready pulse afterwards.
